// File: rtl/dht_uart_framer.sv
// dht_uart_framer: waits until every enabled channel reports valid data, latches all channel
// words in one cycle, then streams them byte by byte (MSB first, channel 0 first) into an
// external uart_tx, with a pre-frame gap and inter-channel gaps.
// Build macro DHT_FRAME_CHECKSUM_EN adds a 0xA5 header byte and a trailing XOR checksum byte.
module dht_uart_framer #(
    parameter int unsigned N_CH       = 3,
    parameter int unsigned WORD_BYTES = 4,
    parameter int unsigned PRE_GAP    = 10,
    parameter int unsigned CH_GAP     = 10
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N_CH-1:0]    data_valid,
    input  logic [32*N_CH-1:0] sensor_data,
    input  logic [N_CH-1:0]    ch_enable,
    input  logic               continuous,
    input  logic               tx_busy,
    output logic [7:0]         tx_data,
    output logic               tx_send,
    output logic               frame_active,
    output logic               frame_done,
    output logic [2:0]         ch_index,
    output logic [2:0]         debug_state
);

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StPre  = 3'd1,
        StLoad = 3'd2,
        StSend = 3'd3,
        StWait = 3'd4,
        StGap  = 3'd5,
        StDone = 3'd6
    } state_e;

    localparam logic [15:0] PreLast  = 16'(PRE_GAP - 1);
    localparam logic [15:0] GapLast  = 16'(CH_GAP - 1);
    localparam logic [1:0]  ByteLast = 2'(WORD_BYTES - 1);

    state_e          state_q, state_d;
    logic [31:0]     words_q [N_CH];
    logic [N_CH-1:0] en_q;
    logic [2:0]      ch_q, ch_d;
    logic [1:0]      byte_q, byte_d;
    logic [15:0]     cnt_q, cnt_d;
    logic            busy_seen_q, busy_seen_d;
    logic            latch;
    logic            trigger;
    logic [2:0]      first_ch;
    logic [2:0]      next_ch;
    logic            has_next;
    logic [31:0]     cur_word;
    logic [4:0]      shamt;
    logic [7:0]      cur_byte;
    logic [7:0]      load_byte;

`ifdef DHT_FRAME_CHECKSUM_EN
    typedef enum logic [1:0] {PhHdr, PhData, PhSum} phase_e;
    phase_e     phase_q, phase_d;
    logic [7:0] csum_q, csum_d;
`endif

    assign trigger      = (|ch_enable) && (&(data_valid | ~ch_enable));
    assign ch_index     = ch_q;
    assign debug_state  = state_q;
    assign frame_active = state_q inside {StPre, StLoad, StSend, StWait, StGap};

    // Channel selection: lowest enabled at trigger, next higher enabled in the latched set.
    always_comb begin
        first_ch = '0;
        next_ch  = '0;
        has_next = 1'b0;
        for (int i = int'(N_CH) - 1; i >= 0; i--) begin
            if (ch_enable[i]) first_ch = 3'(i);
            if (en_q[i] && (i > int'(ch_q))) begin
                has_next = 1'b1;
                next_ch  = 3'(i);
            end
        end
    end

    // Current payload byte; byte_q == 0 selects the most significant used byte.
    always_comb begin
        cur_word = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            if (ch_q == 3'(i)) cur_word = words_q[i];
        end
        shamt    = {ByteLast - byte_q, 3'b000};
        cur_byte = 8'(cur_word >> shamt);
`ifdef DHT_FRAME_CHECKSUM_EN
        if (phase_q == PhHdr)      load_byte = 8'hA5;
        else if (phase_q == PhSum) load_byte = csum_q;
        else                       load_byte = cur_byte;
`else
        load_byte = cur_byte;
`endif
    end

    // Next-state logic and strobes.
    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        byte_d      = byte_q;
        cnt_d       = cnt_q;
        busy_seen_d = busy_seen_q;
        latch       = 1'b0;
        tx_send     = 1'b0;
        tx_data     = 8'h00;
        frame_done  = 1'b0;
`ifdef DHT_FRAME_CHECKSUM_EN
        phase_d = phase_q;
        csum_d  = csum_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (trigger) begin
                    latch   = 1'b1;
                    ch_d    = first_ch;
                    byte_d  = '0;
                    cnt_d   = '0;
                    state_d = StPre;
`ifdef DHT_FRAME_CHECKSUM_EN
                    phase_d = PhHdr;
                    csum_d  = '0;
`endif
                end
            end
            StPre: begin
                if (cnt_q >= PreLast) begin
                    cnt_d   = '0;
                    state_d = StLoad;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StLoad: begin
                if (!tx_busy) begin
                    tx_send     = 1'b1;
                    tx_data     = load_byte;
                    busy_seen_d = 1'b0;
                    state_d     = StSend;
`ifdef DHT_FRAME_CHECKSUM_EN
                    if (phase_q == PhData) csum_d = csum_q ^ cur_byte;
`endif
                end
            end
            StSend: begin
                if (tx_busy) busy_seen_d = 1'b1;
                state_d = StWait;
            end
            StWait: begin
                if (tx_busy) begin
                    busy_seen_d = 1'b1;
                end else if (busy_seen_q) begin
`ifdef DHT_FRAME_CHECKSUM_EN
                    if (phase_q == PhHdr) begin
                        phase_d = PhData;
                        state_d = StLoad;
                    end else if (phase_q == PhSum) begin
                        frame_done = 1'b1;
                        state_d    = StDone;
                    end else
`endif
                    if (byte_q != ByteLast) begin
                        byte_d  = byte_q + 2'd1;
                        state_d = StLoad;
                    end else if (has_next) begin
                        ch_d    = next_ch;
                        byte_d  = '0;
                        cnt_d   = '0;
                        state_d = (CH_GAP == 0) ? StLoad : StGap;
                    end else begin
`ifdef DHT_FRAME_CHECKSUM_EN
                        phase_d = PhSum;
                        state_d = StLoad;
`else
                        frame_done = 1'b1;
                        state_d    = StDone;
`endif
                    end
                end
            end
            StGap: begin
                if (cnt_q >= GapLast) begin
                    cnt_d   = '0;
                    state_d = StLoad;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StDone: begin
                if (continuous) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State, counters and the frame snapshot taken at trigger.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            ch_q        <= '0;
            byte_q      <= '0;
            cnt_q       <= '0;
            busy_seen_q <= 1'b0;
            en_q        <= '0;
            for (int i = 0; i < int'(N_CH); i++) words_q[i] <= '0;
`ifdef DHT_FRAME_CHECKSUM_EN
            phase_q <= PhHdr;
            csum_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            byte_q      <= byte_d;
            cnt_q       <= cnt_d;
            busy_seen_q <= busy_seen_d;
`ifdef DHT_FRAME_CHECKSUM_EN
            phase_q <= phase_d;
            csum_q  <= csum_d;
`endif
            if (latch) begin
                en_q <= ch_enable;
                for (int i = 0; i < int'(N_CH); i++) words_q[i] <= sensor_data[32*i +: 32];
            end
        end
    end

endmodule

// File: tb/tb_dht_uart_framer.sv
// Bench for dht_uart_framer: a uart_tx busy model plus a frame-level reference that lists the
// expected byte stream from the latched words and enables, with cycle-timing expectations.
module tb_dht_uart_framer;

    localparam int N_CH    = 3;
    localparam int WB      = 4;
    localparam int PRE_GAP = 10;
    localparam int CH_GAP  = 10;

    logic               clk         = 1'b0;
    logic               reset_n     = 1'b0;
    logic [N_CH-1:0]    data_valid  = '0;
    logic [32*N_CH-1:0] sensor_data = '0;
    logic [N_CH-1:0]    ch_enable   = '0;
    logic               continuous  = 1'b0;
    logic               tx_busy     = 1'b0;
    logic [7:0]         tx_data;
    logic               tx_send;
    logic               frame_active;
    logic               frame_done;
    logic [2:0]         ch_index;
    logic [2:0]         debug_state;

    int n_checks  = 0;
    int n_pass    = 0;
    int cyc       = 0;
    int busy_cnt  = 0;
    int hold_cnt  = 0;
    bit rand_hold = 1'b0;
    bit rand_len  = 1'b0;
    logic [7:0] exp_q[$];
    int         exp_ch[$];
    int         nexp;

    dht_uart_framer #(
        .N_CH      (N_CH),
        .WORD_BYTES(WB),
        .PRE_GAP   (PRE_GAP),
        .CH_GAP    (CH_GAP)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .data_valid  (data_valid),
        .sensor_data (sensor_data),
        .ch_enable   (ch_enable),
        .continuous  (continuous),
        .tx_busy     (tx_busy),
        .tx_data     (tx_data),
        .tx_send     (tx_send),
        .frame_active(frame_active),
        .frame_done  (frame_done),
        .ch_index    (ch_index),
        .debug_state (debug_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // One clock: update the uart busy model just after the edge, return at the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (busy_cnt > 0) begin
            tx_busy = 1'b1;
            busy_cnt--;
        end else if (hold_cnt > 0) begin
            tx_busy = 1'b1;
            hold_cnt--;
        end else begin
            tx_busy = 1'b0;
            if (rand_hold && $urandom_range(0, 15) == 0) hold_cnt = $urandom_range(1, 8);
        end
        @(negedge clk);
    endtask

    function automatic logic [32*N_CH-1:0] rand_words();
        logic [32*N_CH-1:0] w;
        for (int i = 0; i < N_CH; i++) w[32*i +: 32] = $urandom();
        return w;
    endfunction

    // Expected frame: optional header, enabled channels in ascending order, MSB byte first.
    task automatic build_expected(input logic [32*N_CH-1:0] data, input logic [N_CH-1:0] en);
        logic [31:0] w;
        logic [7:0]  b;
        logic [7:0]  csum;
        exp_q.delete();
        exp_ch.delete();
        csum = 8'h00;
`ifdef DHT_FRAME_CHECKSUM_EN
        exp_q.push_back(8'hA5);
        exp_ch.push_back(-1);
`endif
        for (int ch = 0; ch < N_CH; ch++) begin
            if (en[ch]) begin
                w = data[32*ch +: 32];
                for (int k = 0; k < WB; k++) begin
                    b = w[8*(WB-1-k) +: 8];
                    exp_q.push_back(b);
                    exp_ch.push_back(ch);
                    csum ^= b;
                end
            end
        end
`ifdef DHT_FRAME_CHECKSUM_EN
        exp_q.push_back(csum);
        exp_ch.push_back(-1);
`endif
        nexp = exp_q.size();
    endtask

    task automatic reset_dut();
        @(negedge clk);
        reset_n    = 1'b0;
        data_valid = '0;
        ch_enable  = '0;
        continuous = 1'b0;
        tx_busy    = 1'b0;
        busy_cnt   = 0;
        hold_cnt   = 0;
        rand_hold  = 1'b0;
        #1;
        check("rst_tx_send", tx_send, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_active", frame_active, 0);
        check("rst_done", frame_done, 0);
        check("rst_state", debug_state, 0);
        check("rst_ch_index", ch_index, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // Inputs that must not start a frame.
    task automatic idle_check(input logic [N_CH-1:0] en, input logic [N_CH-1:0] valid);
        int sends;
        sends       = 0;
        ch_enable   = en;
        data_valid  = valid;
        sensor_data = rand_words();
        repeat (30) begin
            step();
            if (tx_send) sends++;
        end
        check("no_trigger_sends", sends, 0);
        check("no_trigger_state", debug_state, 0);
        check("no_trigger_active", frame_active, 0);
        data_valid = '0;
        ch_enable  = '0;
    endtask

    task automatic run_frame(input logic [32*N_CH-1:0] data, input logic [N_CH-1:0] en,
                             input logic [N_CH-1:0] valid, input bit cont, input int nframes,
                             input int abort_at, input bit stall);
        int t0, first_exp, sent, last_complete, prev_ch, frames_done, extra, c, ech;
        bit pending, seen, aborted;
        logic [7:0] eb;
        sensor_data = data;
        ch_enable   = en;
        data_valid  = valid;
        continuous  = cont;
        t0 = cyc;
        build_expected(data, en);
        first_exp = -1; sent = 0; last_complete = -1; prev_ch = -1; frames_done = 0;
        pending = 1'b0; seen = 1'b0; aborted = 1'b0;
        for (int k = 0; k < 6000 && frames_done < nframes && !aborted; k++) begin
            step();
            c = cyc;
            if (!cont) begin
                sensor_data = rand_words();
                data_valid  = N_CH'($urandom());
                ch_enable   = N_CH'($urandom());
            end
            if (stall && c == t0 + PRE_GAP - 1) hold_cnt = 50;
            // A byte completes on the first low-busy cycle after busy was seen high.
            if (pending) begin
                if (tx_busy) seen = 1'b1;
                else if (seen) begin
                    pending       = 1'b0;
                    last_complete = c;
                end
            end
            if (sent == 0 && first_exp < 0 && c >= t0 + PRE_GAP + 1 && !tx_busy) first_exp = c;
            if (tx_send) begin
                check("send_while_busy", tx_busy, 0);
                check("active_on_send", frame_active, 1);
                if (exp_q.size() == 0) begin
                    check("bytes_in_frame", sent + 1, nexp);
                end else begin
                    eb  = exp_q.pop_front();
                    ech = exp_ch.pop_front();
                    check("tx_data", tx_data, eb);
                    if (ech >= 0) check("ch_index", ch_index, ech);
                    if (sent == 0) check("first_send_cycle", c, first_exp);
                    if (ech >= 0 && prev_ch >= 0 && ech != prev_ch)
                        check("ch_gap", (c - last_complete - 1) >= CH_GAP, 1);
                    if (ech >= 0) prev_ch = ech;
                end
                sent++;
                pending  = 1'b1;
                seen     = 1'b0;
                busy_cnt = rand_len ? $urandom_range(1, 30) : 20;
                if (sent == abort_at) begin
                    reset_n = 1'b0;
                    #1;
                    check("abort_tx_send", tx_send, 0);
                    check("abort_active", frame_active, 0);
                    check("abort_state", debug_state, 0);
                    busy_cnt   = 0;
                    hold_cnt   = 0;
                    tx_busy    = 1'b0;
                    data_valid = '0;
                    ch_enable  = '0;
                    @(negedge clk);
                    reset_n = 1'b1;
                    @(negedge clk);
                    aborted = 1'b1;
                end
            end
            if (!aborted && frame_done) begin
                check("done_at_last_byte", c, last_complete);
                check("done_byte_count", sent, nexp);
                frames_done++;
                if (cont && frames_done < nframes) begin
                    t0 = c + 2;
                    build_expected(data, en);
                    sent = 0; first_exp = -1; prev_ch = -1;
                end
            end
        end
        if (!aborted) begin
            check("frames_completed", frames_done, nframes);
            if (!cont) begin
                extra = 0;
                repeat (20) begin
                    step();
                    if (tx_send || frame_done) extra++;
                end
                check("done_quiet", extra, 0);
                check("done_state", debug_state, 6);
                check("done_active", frame_active, 0);
            end
        end
    endtask

    initial begin
        logic [32*N_CH-1:0] d;
        logic [N_CH-1:0]    en;
        reset_dut();

        // Three channels, fixed 20-cycle uart busy.
        rand_len = 1'b0;
        run_frame({32'h99AABBCC, 32'h55667788, 32'h11223344}, 3'b111, 3'b111, 1'b0, 1, -1, 1'b0);

        // No enabled channel, or an enabled channel not yet valid: no frame.
        reset_dut();
        idle_check(3'b000, 3'b111);
        idle_check(3'b101, 3'b001);

        // Disabled channel 1 with its valid low is skipped entirely.
        run_frame({32'h99AABBCC, 32'h55667788, 32'h11223344}, 3'b101, 3'b101, 1'b0, 1, -1, 1'b0);

        // uart busy held across LOAD entry for 50 cycles.
        reset_dut();
        run_frame({32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF}, 3'b111, 3'b111, 1'b0, 1, -1, 1'b1);

        // Reset during byte 5 aborts; the next frame starts over at channel 0 byte 0.
        reset_dut();
        run_frame({32'h99AABBCC, 32'h55667788, 32'h11223344}, 3'b111, 3'b111, 1'b0, 1, 5, 1'b0);
        run_frame({32'h99AABBCC, 32'h55667788, 32'h11223344}, 3'b111, 3'b111, 1'b0, 1, -1, 1'b0);

        // Continuous framing, back-to-back frames.
        reset_dut();
        rand_len = 1'b1;
        run_frame(rand_words(), 3'b111, 3'b111, 1'b1, 3, -1, 1'b0);

        // Single channel word.
        reset_dut();
        rand_len = 1'b0;
        run_frame({32'h0, 32'h0, 32'h01020304}, 3'b001, 3'b001, 1'b0, 1, -1, 1'b0);

        // Randomised frames with random busy lengths and external busy holds.
        for (int r = 0; r < 6; r++) begin
            reset_dut();
            rand_len  = 1'b1;
            rand_hold = 1'b1;
            en = N_CH'($urandom_range(1, (1 << N_CH) - 1));
            d  = rand_words();
            run_frame(d, en, en | N_CH'($urandom()), 1'b0, 1, -1, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
